// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
package reset_seq_pkg;

    localparam int unsigned STAGES_DEFAULT         = 4;
    localparam int unsigned HOLD_CYCLES_DEFAULT    = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

    typedef enum logic [2:0] {
        StWaitLock,
        StHold,
        StWaitReady,
        StRun,
        StFault
    } seq_state_e;

    // Width of a counter/index over 'value' states; never narrower than 1 bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, asynchronously cleared to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_req_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk or negedge reset_req_l) begin
        if (!reset_req_l) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream reset domains in ascending order once the PLL is stably locked,
// waiting for each domain's ready acknowledge and flagging a fault on timeout.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned STAGES         = STAGES_DEFAULT,
    parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset_req_l,
    input  logic                           pll_locked,
    input  logic [STAGES-1:0]              stage_ready,
    input  logic                           sw_reset_req,
    output logic [STAGES-1:0]              stage_reset_l,
    output logic                           all_ready,
    output logic                           fault,
    output logic [clog2_min1(STAGES)-1:0]  fault_stage
);

    localparam int unsigned IdxW  = clog2_min1(STAGES);
    localparam int unsigned HoldW = clog2_min1(HOLD_CYCLES);
    localparam int unsigned ToW   = clog2_min1(TIMEOUT_CYCLES);

    localparam logic [IdxW-1:0]  LastIdx = IdxW'(STAGES - 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);
    localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT_CYCLES - 1);

    seq_state_e       state_q;
    logic [IdxW-1:0]  idx_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic [ToW-1:0]   to_cnt_q;

    logic [STAGES:0]   sync_q;
    logic              lock_s;
    logic [STAGES-1:0] ready_s;

    sync_2ff #(
        .WIDTH(STAGES + 1)
    ) u_sync (
        .clk        (clk),
        .reset_req_l(reset_req_l),
        .d          ({stage_ready, pll_locked}),
        .q          (sync_q)
    );

    assign lock_s  = sync_q[0];
    assign ready_s = sync_q[STAGES:1];

    // Ready bit of the stage being waited on, and the one-hot of the stage released next.
    logic              ready_sel;
    logic [STAGES-1:0] next_release;

    always_comb begin
        ready_sel    = 1'b0;
        next_release = '0;
        for (int j = 0; j < STAGES; j++) begin
            if (j == int'(idx_q)) begin
                ready_sel = ready_s[j];
            end
            if (j == int'(idx_q) + 1) begin
                next_release[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_req_l) begin
        if (!reset_req_l) begin
            state_q       <= StWaitLock;
            idx_q         <= '0;
            hold_cnt_q    <= '0;
            to_cnt_q      <= '0;
            stage_reset_l <= '0;
            all_ready     <= 1'b0;
            fault         <= 1'b0;
            fault_stage   <= '0;
        end else if (state_q == StFault) begin
            // Sticky until software clears it; lock loss alone does not.
            if (sw_reset_req) begin
                state_q <= StWaitLock;
                fault   <= 1'b0;
            end
        end else if (state_q != StWaitLock && (sw_reset_req || !lock_s)) begin
            state_q       <= StWaitLock;
            idx_q         <= '0;
            hold_cnt_q    <= '0;
            to_cnt_q      <= '0;
            stage_reset_l <= '0;
            all_ready     <= 1'b0;
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    if (lock_s) begin
                        state_q    <= StHold;
                        hold_cnt_q <= '0;
                    end
                end
                StHold: begin
                    if (hold_cnt_q == HoldMax) begin
                        state_q          <= StWaitReady;
                        idx_q            <= '0;
                        to_cnt_q         <= '0;
                        stage_reset_l[0] <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                StWaitReady: begin
                    if (ready_sel) begin
                        to_cnt_q <= '0;
                        if (idx_q == LastIdx) begin
                            state_q   <= StRun;
                            all_ready <= 1'b1;
                        end else begin
                            idx_q         <= idx_q + 1'b1;
                            stage_reset_l <= stage_reset_l | next_release;
                        end
                    end else if (to_cnt_q == ToMax) begin
                        state_q       <= StFault;
                        fault         <= 1'b1;
                        fault_stage   <= idx_q;
                        stage_reset_l <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    all_ready <= 1'b1;
                end
                default: begin
                    state_q <= StWaitLock;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timed expectation tables queued against a cycle counter.
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_req_l;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       loop_mode;
    logic [3:0] ready_mask;
    logic [3:0] stage_ready;
    logic [3:0] stage_reset_l;
    logic       all_ready;
    logic       fault;
    logic [1:0] fault_stage;

    logic       lock1;
    logic       sw1;
    logic       ready1;
    logic       rst1;
    logic       all_ready1;
    logic       fault1;
    logic [0:0] fault_stage1;

    // Loop mode models a domain that acknowledges as soon as its reset is released.
    assign stage_ready = loop_mode ? (stage_reset_l & ready_mask) : ready_mask;

    reset_sequencer #(
        .STAGES        (4),
        .HOLD_CYCLES   (16),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk          (clk),
        .reset_req_l  (reset_req_l),
        .pll_locked   (pll_locked),
        .stage_ready  (stage_ready),
        .sw_reset_req (sw_reset_req),
        .stage_reset_l(stage_reset_l),
        .all_ready    (all_ready),
        .fault        (fault),
        .fault_stage  (fault_stage)
    );

    reset_sequencer #(
        .STAGES        (1),
        .HOLD_CYCLES   (1),
        .TIMEOUT_CYCLES(8)
    ) dut1 (
        .clk          (clk),
        .reset_req_l  (reset_req_l),
        .pll_locked   (lock1),
        .stage_ready  (ready1),
        .sw_reset_req (sw1),
        .stage_reset_l(rst1),
        .all_ready    (all_ready1),
        .fault        (fault1),
        .fault_stage  (fault_stage1)
    );

    typedef struct {
        string      name;
        int         dly;
        logic [3:0] rst;
        logic       ar;
        logic       f;
        logic [1:0] fs;
        bit         chk_fs;
    } vec_t;

    typedef struct {
        int   at;
        bit   sel;
        vec_t v;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   nvec  = 0;
    int   nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input string name, input int dly, input logic [3:0] rst,
                                input logic ar, input logic f, input logic [1:0] fs,
                                input bit chk_fs);
        vec_t v;
        v.name   = name;
        v.dly    = dly;
        v.rst    = rst;
        v.ar     = ar;
        v.f      = f;
        v.fs     = fs;
        v.chk_fs = chk_fs;
        return v;
    endfunction

    task automatic compare(input bit sel, input vec_t v);
        logic [3:0] got_rst;
        logic       got_ar;
        logic       got_f;
        logic [1:0] got_fs;
        bit         ok;
        if (sel) begin
            got_rst = {3'b000, rst1};
            got_ar  = all_ready1;
            got_f   = fault1;
            got_fs  = {1'b0, fault_stage1};
        end else begin
            got_rst = stage_reset_l;
            got_ar  = all_ready;
            got_f   = fault;
            got_fs  = fault_stage;
        end
        ok = (got_rst === v.rst) && (got_ar === v.ar) && (got_f === v.f) &&
             (!v.chk_fs || got_fs === v.fs);
        nvec++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s @cyc %0d: got rst=%b ar=%b f=%b fs=%0d, want rst=%b ar=%b f=%b fs=%0d",
                     v.name, cyc, got_rst, got_ar, got_f, got_fs, v.rst, v.ar, v.f, v.fs);
        end
    endtask

    task automatic push_table(input vec_t t[$], input int base, input bit sel);
        exp_t e;
        foreach (t[i]) begin
            e.at  = base + t[i].dly;
            e.sel = sel;
            e.v   = t[i];
            sb.push_back(e);
        end
    endtask

    task automatic service();
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) begin
                nvec++;
                nfail++;
                $display("FAIL %s: slot cycle %0d skipped, now %0d", e.v.name, e.at, cyc);
            end else begin
                compare(e.sel, e.v);
            end
        end
    endtask

    // Outputs are sampled at the falling edge; inputs change 2 time units after the rising edge.
    task automatic step();
        @(negedge clk);
        service();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() > 0) begin
            nvec++;
            nfail++;
            $display("FAIL drain: %0d checks never reached, want 0", sb.size());
            sb.delete();
        end
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t tbl_c[$];
    vec_t tbl_clr[$];
    vec_t tbl_f[$];
    vec_t tbl_g1[$];
    vec_t tbl_g2[$];
    vec_t one[$];
    int   c;

    initial begin
        tbl_a = '{mk("a_hold_end", 18, 4'b0000, 0, 0, 0, 1), mk("a_rel0", 19, 4'b0001, 0, 0, 0, 1),
                  mk("a_sync_wait", 21, 4'b0001, 0, 0, 0, 1), mk("a_rel1", 22, 4'b0011, 0, 0, 0, 1),
                  mk("a_rel1_hold", 24, 4'b0011, 0, 0, 0, 1), mk("a_rel2", 25, 4'b0111, 0, 0, 0, 1),
                  mk("a_rel3", 28, 4'b1111, 0, 0, 0, 1), mk("a_pre_run", 30, 4'b1111, 0, 0, 0, 1),
                  mk("a_run", 31, 4'b1111, 1, 0, 0, 1)};
        tbl_b = '{mk("b_sw_assert", 1, 4'b0000, 0, 0, 0, 1), mk("b_hold", 17, 4'b0000, 0, 0, 0, 1),
                  mk("b_rel0", 18, 4'b0001, 0, 0, 0, 1), mk("b_rel3", 27, 4'b1111, 0, 0, 0, 1),
                  mk("b_run", 30, 4'b1111, 1, 0, 0, 1)};
        tbl_c = '{mk("c_no_early", 19, 4'b0000, 0, 0, 0, 1), mk("c_hold_end", 30, 4'b0000, 0, 0, 0, 1),
                  mk("c_rel0", 31, 4'b0001, 0, 0, 0, 1), mk("c_rel1", 34, 4'b0011, 0, 0, 0, 1),
                  mk("c_rel2", 37, 4'b0111, 0, 0, 0, 1), mk("d_pre_to", 1060, 4'b0111, 0, 0, 0, 1),
                  mk("d_fault", 1061, 4'b0000, 0, 1, 2, 1)};
        tbl_clr = '{mk("d_clear", 1, 4'b0000, 0, 0, 0, 0), mk("d_hold", 17, 4'b0000, 0, 0, 0, 0),
                    mk("d_rel0", 18, 4'b0001, 0, 0, 0, 0), mk("d_run", 30, 4'b1111, 1, 0, 0, 0)};
        tbl_f = '{mk("f_rel0", 18, 4'b0001, 0, 0, 0, 0), mk("f_rel1", 19, 4'b0011, 0, 0, 0, 0),
                  mk("f_rel2", 20, 4'b0111, 0, 0, 0, 0), mk("f_rel3", 21, 4'b1111, 0, 0, 0, 0),
                  mk("f_run", 22, 4'b1111, 1, 0, 0, 0)};
        tbl_g1 = '{mk("g_hold", 3, 4'b0000, 0, 0, 0, 1), mk("g_rel", 4, 4'b0001, 0, 0, 0, 1),
                   mk("g_run", 5, 4'b0001, 1, 0, 0, 1)};
        tbl_g2 = '{mk("g_sw", 1, 4'b0000, 0, 0, 0, 1), mk("g_rel_again", 3, 4'b0001, 0, 0, 0, 1),
                   mk("g_pre_to", 10, 4'b0001, 0, 0, 0, 1), mk("g_fault", 11, 4'b0000, 0, 1, 0, 1)};

        reset_req_l  = 1'b0;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
        loop_mode    = 1'b1;
        ready_mask   = 4'b1111;
        lock1        = 1'b0;
        sw1          = 1'b0;
        ready1       = 1'b1;
        #1;
        compare(0, mk("reset_main", 0, 4'b0000, 0, 0, 0, 1));
        compare(1, mk("reset_small", 0, 4'b0000, 0, 0, 0, 1));
        @(posedge clk);
        #2;
        step();
        reset_req_l = 1'b1;
        one = '{mk("idle_no_lock", 10, 4'b0000, 0, 0, 0, 1)};
        push_table(one, cyc, 0);
        drain(20);

        // Power-up sequence with self-acknowledging domains.
        c = cyc;
        pll_locked = 1'b1;
        push_table(tbl_a, c, 0);
        drain(40);

        // Software reset while running.
        c = cyc;
        sw_reset_req = 1'b1;
        push_table(tbl_b, c, 0);
        step();
        sw_reset_req = 1'b0;
        drain(40);

        // Hard reset in the middle of waiting on stage 1.
        c = cyc;
        sw_reset_req = 1'b1;
        one = '{mk("e_in_wr1", 21, 4'b0011, 0, 0, 0, 1)};
        push_table(one, c, 0);
        step();
        sw_reset_req = 1'b0;
        while (cyc < c + 22) step();
        reset_req_l = 1'b0;
        #1;
        compare(0, mk("e_async_abort", 0, 4'b0000, 0, 0, 0, 1));
        step();
        step();
        c = cyc;
        reset_req_l = 1'b1;
        push_table(tbl_a, c, 0);
        drain(40);

        // Lock glitch at hold count 10, then stage 2 never acknowledges.
        pll_locked = 1'b0;
        ready_mask = 4'b1011;
        repeat (5) step();
        c = cyc;
        pll_locked = 1'b1;
        push_table(tbl_c, c, 0);
        repeat (11) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        drain(1200);

        pll_locked = 1'b0;
        c = cyc;
        one = '{mk("d_sticky_a", 4, 4'b0000, 0, 1, 2, 1), mk("d_sticky_b", 8, 4'b0000, 0, 1, 2, 1)};
        push_table(one, c, 0);
        drain(20);
        pll_locked = 1'b1;
        repeat (3) step();

        c = cyc;
        sw_reset_req = 1'b1;
        ready_mask   = 4'b1111;
        push_table(tbl_clr, c, 0);
        step();
        sw_reset_req = 1'b0;
        drain(40);

        // Readies already high: each stage accepted one cycle after its release.
        c = cyc;
        sw_reset_req = 1'b1;
        loop_mode    = 1'b0;
        push_table(tbl_f, c, 0);
        step();
        sw_reset_req = 1'b0;
        drain(40);

        // Software reset and lock loss together.
        c = cyc;
        sw_reset_req = 1'b1;
        pll_locked   = 1'b0;
        one = '{mk("h_one_event", 1, 4'b0000, 0, 0, 0, 0), mk("h_stays_idle", 12, 4'b0000, 0, 0, 0, 0)};
        push_table(one, c, 0);
        step();
        sw_reset_req = 1'b0;
        drain(20);

        // Single-stage instance with a one-cycle hold and short timeout.
        c = cyc;
        lock1 = 1'b1;
        push_table(tbl_g1, c, 1);
        drain(20);
        c = cyc;
        sw1    = 1'b1;
        ready1 = 1'b0;
        push_table(tbl_g2, c, 1);
        step();
        sw1 = 1'b0;
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
